// File: rtl/clock_pkg.sv
// Shared mode encoding and small constant helpers for the clock time-setting control path.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Mode button walks the ring RUN -> HOUR -> MIN -> SEC -> RUN.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_RUN:      return MODE_SET_HOUR;
            MODE_SET_HOUR: return MODE_SET_MIN;
            MODE_SET_MIN:  return MODE_SET_SEC;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Rising-edge detect plus hold-to-repeat for one button; pulse_o is a
// combinational one-cycle strobe meaning "issue an increment at this edge".
module key_repeat #(
    parameter int unsigned DELAY  = 50_000_000,
    parameter int unsigned PERIOD = 10_000_000,
    parameter int unsigned CW     = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic enable_i,
    input  logic disarm_i,
    output logic pulse_o
);

    localparam logic [CW-1:0] DELAY_C  = CW'(DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);

    logic          btn_d_q;
    logic          armed_q, armed_d;
    logic          in_delay_q, in_delay_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise;
    logic [CW-1:0] limit;

    assign rise  = btn_i & ~btn_d_q;
    assign limit = in_delay_q ? DELAY_C : PERIOD_C;

    // cnt_q holds cycles since the last pulse; it reloads on every pulse so it never exceeds max(DELAY, PERIOD).
    always_comb begin
        armed_d    = armed_q;
        in_delay_d = in_delay_q;
        cnt_d      = cnt_q;
        pulse_o    = 1'b0;
        if (!btn_i || !enable_i || disarm_i) begin
            armed_d    = 1'b0;
            in_delay_d = 1'b0;
            cnt_d      = '0;
        end else if (rise) begin
            pulse_o    = 1'b1;
            armed_d    = 1'b1;
            in_delay_d = 1'b1;
            cnt_d      = CW'(1);
        end else if (armed_q) begin
            if (cnt_q == limit) begin
                pulse_o    = 1'b1;
                in_delay_d = 1'b0;
                cnt_d      = CW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_d_q    <= 1'b0;
            armed_q    <= 1'b0;
            in_delay_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            btn_d_q    <= btn_i;
            armed_q    <= armed_d;
            in_delay_q <= in_delay_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_cu.sv
// Time-setting control unit: mode FSM, increment pulse routing and field blink.
// Optional idle auto-exit back to RUN is enabled with `define AUTO_EXIT_EN.
module clock_set_cu
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned BLINK_HALF    = 25_000_000,
    parameter int unsigned IDLE_TIMEOUT  = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       o_btn_hour,
    output logic       o_btn_min,
    output logic       o_btn_sec,
    output logic [1:0] o_mode,
    output logic       o_blank_hour,
    output logic       o_blank_min,
    output logic       o_blank_sec
);

    localparam int unsigned CW = $clog2(max2(max2(REPEAT_DELAY, REPEAT_PERIOD),
                                             max2(BLINK_HALF, IDLE_TIMEOUT))) + 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

    mode_t         mode_q, mode_d;
    logic          btn_mode_d_q;
    logic          mode_rise;
    logic          mode_change;
    logic          timeout;
    logic          up_enable;
    logic          fire;
    logic [2:0]    pulse_q, pulse_d;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    assign mode_rise   = btn_mode & ~btn_mode_d_q;
    assign mode_change = (mode_d != mode_q);
    assign up_enable   = (mode_q != MODE_RUN);

`ifdef AUTO_EXIT_EN
    localparam logic [CW-1:0] IDLE_LIMIT = CW'(IDLE_TIMEOUT);
    logic [CW-1:0] idle_q, idle_d;

    assign timeout = (mode_q != MODE_RUN) && (idle_q == IDLE_LIMIT);

    always_comb begin
        idle_d = idle_q;
        if ((mode_d == MODE_RUN) || btn_mode || btn_up) begin
            idle_d = '0;
        end else if (idle_q != IDLE_LIMIT) begin
            idle_d = idle_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        mode_d = mode_q;
        if (timeout) begin
            mode_d = MODE_RUN;
        end else if (mode_rise) begin
            mode_d = next_mode(mode_q);
        end
    end

    // A mode change at an edge disarms the repeater, so a simultaneous up rise never pulses.
    key_repeat #(
        .DELAY  (REPEAT_DELAY),
        .PERIOD (REPEAT_PERIOD),
        .CW     (CW)
    ) u_key_repeat (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_up),
        .enable_i (up_enable),
        .disarm_i (mode_change),
        .pulse_o  (fire)
    );

    always_comb begin
        pulse_d = 3'b000;
        if (fire) begin
            case (mode_q)
                MODE_SET_HOUR: pulse_d = 3'b100;
                MODE_SET_MIN:  pulse_d = 3'b010;
                MODE_SET_SEC:  pulse_d = 3'b001;
                default:       pulse_d = 3'b000;
            endcase
        end
    end

    // Blink restarts visible on SET entry and on each increment so the field stays readable while adjusting.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if ((mode_d == MODE_RUN) || mode_change || fire) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_RUN;
            btn_mode_d_q <= 1'b0;
            pulse_q      <= 3'b000;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            btn_mode_d_q <= btn_mode;
            pulse_q      <= pulse_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign o_mode       = mode_q;
    assign o_btn_hour   = pulse_q[2];
    assign o_btn_min    = pulse_q[1];
    assign o_btn_sec    = pulse_q[0];
    assign o_blank_hour = phase_q & (mode_q == MODE_SET_HOUR);
    assign o_blank_min  = phase_q & (mode_q == MODE_SET_MIN);
    assign o_blank_sec  = phase_q & (mode_q == MODE_SET_SEC);

endmodule

// File: tb/tb_clock_set_cu.sv
// Bench for clock_set_cu: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural model. Honours `define AUTO_EXIT_EN.
module tb_clock_set_cu;

    localparam int RD = 8;
    localparam int RP = 3;
    localparam int BH = 4;
    localparam int IT = 20;
`ifdef AUTO_EXIT_EN
    localparam bit AUTO_EXIT = 1'b1;
`else
    localparam bit AUTO_EXIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_up;
    logic       o_btn_hour, o_btn_min, o_btn_sec;
    logic [1:0] o_mode;
    logic       o_blank_hour, o_blank_min, o_blank_sec;
    logic [7:0] outs_w;

    int total = 0;
    int bad   = 0;

    clock_set_cu #(
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .BLINK_HALF    (BH),
        .IDLE_TIMEOUT  (IT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_mode     (btn_mode),
        .btn_up       (btn_up),
        .o_btn_hour   (o_btn_hour),
        .o_btn_min    (o_btn_min),
        .o_btn_sec    (o_btn_sec),
        .o_mode       (o_mode),
        .o_blank_hour (o_blank_hour),
        .o_blank_min  (o_blank_min),
        .o_blank_sec  (o_blank_sec)
    );

    always #5 clk = ~clk;

    assign outs_w = {o_mode, o_btn_hour, o_btn_min, o_btn_sec,
                     o_blank_hour, o_blank_min, o_blank_sec};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic m, input logic u);
        btn_mode = m;
        btn_up   = u;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Behavioural model: pulse times are ages measured from the first pulse,
    // blink phase is (cycles since restart / BH) mod 2.
    int         m_mode, m_pm, m_pu, m_armed, m_age, m_bage, m_idle;
    logic [7:0] m_exp;

    task automatic model_reset();
        m_mode = 0; m_pm = 0; m_pu = 0; m_armed = 0;
        m_age = 0; m_bage = 0; m_idle = 0; m_exp = 8'h00;
    endtask

    task automatic model_step(input bit r, input bit m, input bit u);
        int  nm;
        bit  mr, ur, tmo, changed, fire, phase;
        logic [2:0] pl, bl;
        if (r) begin
            model_reset();
            return;
        end
        mr  = m && !m_pm[0];
        ur  = u && !m_pu[0];
        tmo = AUTO_EXIT && (m_mode != 0) && (m_idle == IT);
        nm  = tmo ? 0 : (mr ? (m_mode + 1) % 4 : m_mode);
        changed = (nm != m_mode);
        fire = 1'b0;
        if (!u || m_mode == 0 || changed) begin
            m_armed = 0;
        end else if (ur) begin
            fire = 1'b1; m_armed = 1; m_age = 0;
        end else if (m_armed != 0) begin
            m_age++;
            if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) fire = 1'b1;
        end
        if (nm == 0 || changed || fire) m_bage = 0;
        else m_bage++;
        phase = ((m_bage / BH) % 2) == 1;
        if (nm == 0 || m || u) m_idle = 0;
        else if (m_idle < IT) m_idle++;
        pl = 3'b000;
        if (fire) pl = (m_mode == 1) ? 3'b100 : (m_mode == 2) ? 3'b010 : (m_mode == 3) ? 3'b001 : 3'b000;
        bl = 3'b000;
        if (phase) bl = (nm == 1) ? 3'b100 : (nm == 2) ? 3'b010 : (nm == 3) ? 3'b001 : 3'b000;
        m_exp  = {nm[1:0], pl, bl};
        m_mode = nm;
        m_pm   = m ? 1 : 0;
        m_pu   = u ? 1 : 0;
    endtask

    typedef struct packed {
        logic       m;
        logic       u;
        logic [1:0] mode;
        logic [2:0] pls;
        logic [2:0] blk;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int pulses, others, exp_b;
        logic mv, uv;
        bit   r;

        tbl[0]  = '{1'b1, 1'b0, 2'd1, 3'b000, 3'b000};
        tbl[1]  = '{1'b0, 1'b0, 2'd1, 3'b000, 3'b000};
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 3'b000, 3'b000};
        tbl[3]  = '{1'b0, 1'b0, 2'd2, 3'b000, 3'b000};
        tbl[4]  = '{1'b1, 1'b0, 2'd3, 3'b000, 3'b000};
        tbl[5]  = '{1'b0, 1'b0, 2'd3, 3'b000, 3'b000};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 3'b000, 3'b000};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 3'b000, 3'b000};
        tbl[8]  = '{1'b0, 1'b1, 2'd0, 3'b000, 3'b000};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 3'b000, 3'b000};
        tbl[10] = '{1'b1, 1'b0, 2'd1, 3'b000, 3'b000};
        tbl[11] = '{1'b0, 1'b0, 2'd1, 3'b000, 3'b000};
        tbl[12] = '{1'b1, 1'b0, 2'd2, 3'b000, 3'b000};
        tbl[13] = '{1'b0, 1'b0, 2'd2, 3'b000, 3'b000};
        tbl[14] = '{1'b0, 1'b1, 2'd2, 3'b010, 3'b000};
        tbl[15] = '{1'b0, 1'b0, 2'd2, 3'b000, 3'b000};
        tbl[16] = '{1'b0, 1'b0, 2'd2, 3'b000, 3'b000};
        tbl[17] = '{1'b0, 1'b0, 2'd2, 3'b000, 3'b000};
        tbl[18] = '{1'b0, 1'b0, 2'd2, 3'b000, 3'b010};

        // Reset state
        rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", outs_w, 8'h00);
        rst = 1'b0;

        // Mode ring and single presses in RUN / SET_MIN
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].m, tbl[i].u);
            check($sformatf("vec%0d", i), outs_w, {tbl[i].mode, tbl[i].pls, tbl[i].blk});
        end

        // Hold-to-repeat in SET_HOUR
        do_reset();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        pulses = 0; others = 0;
        for (int k = 1; k <= 22; k++) begin
            cyc(1'b0, 1'b1);
            exp_b = (k == 1 || k == 9 || k == 12 || k == 15 || k == 18 || k == 21) ? 1 : 0;
            check($sformatf("repeat_hour_k%0d", k), o_btn_hour, exp_b);
            pulses += o_btn_hour;
            others += o_btn_min + o_btn_sec;
        end
        check("repeat_count", pulses, 6);
        check("repeat_other_fields", others, 0);
        cyc(1'b0, 1'b0);

        // Mode and up rise on the same edge, then a long hold stays disarmed
        cyc(1'b1, 1'b1);
        check("simul_mode", o_mode, 2);
        check("simul_pulse", {o_btn_hour, o_btn_min, o_btn_sec}, 3'b000);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b1);
            pulses += o_btn_hour + o_btn_min + o_btn_sec;
        end
        check("disarmed_pulses", pulses, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("repress_min", {o_btn_hour, o_btn_min, o_btn_sec}, 3'b010);
        cyc(1'b0, 1'b0);

        // Blink in SET_SEC, restarted by an increment
        cyc(1'b1, 1'b0);
        check("enter_sec", o_mode, 3);
        for (int k = 1; k <= 12; k++) begin
            cyc(1'b0, 1'b0);
            check($sformatf("blink_k%0d", k), {o_blank_hour, o_blank_min, o_blank_sec},
                  {2'b00, ((k / BH) % 2) == 1});
        end
        cyc(1'b0, 1'b1);
        check("blink_pulse_sec", {o_btn_hour, o_btn_min, o_btn_sec}, 3'b001);
        check("blink_pulse_vis", {o_blank_hour, o_blank_min, o_blank_sec}, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b0);
            check($sformatf("blink_after_k%0d", k), o_blank_sec, (k == 4) ? 1 : 0);
        end

        // Reset while held in SET_MIN
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        check("pre_rst_mode", o_mode, 2);
        cyc(1'b0, 1'b1);
        check("pre_rst_pulse", o_btn_min, 1);
        cyc(1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b1);
        rst = 1'b0;
        check("mid_rst_outs", outs_w, 8'h00);
        cyc(1'b0, 1'b1);
        check("post_rst_held", outs_w, 8'h00);
        cyc(1'b0, 1'b0);

`ifdef AUTO_EXIT_EN
        do_reset();
        cyc(1'b1, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            cyc(1'b0, 1'b0);
            if (k == 20) check("idle_still_set", o_mode, 1);
        end
        check("idle_exit_mode", o_mode, 0);
        check("idle_exit_blank", {o_blank_hour, o_blank_min, o_blank_sec}, 3'b000);
`endif

        // Randomized run against the model
        do_reset();
        model_reset();
        mv = 1'b0; uv = 1'b0;
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 11) == 0) mv = ~mv;
            if ($urandom_range(0, 8) == 0) uv = ~uv;
            rst = r;
            cyc(mv, uv);
            rst = 1'b0;
            model_step(r, mv, uv);
            check($sformatf("rand%0d", n), outs_w, m_exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
